// File: rtl/spi_packet_rx_if.sv
// rtl/spi_packet_rx_if.sv - packet delivery handshake between spi_packet_rx and its consumer
interface spi_packet_rx_if #(
  parameter int PACKET_BYTES = 16
) ();
  logic [8*PACKET_BYTES-1:0] pkt_data;
  logic                      pkt_valid;
  logic                      pkt_ready;

  modport master (output pkt_data, output pkt_valid, input pkt_ready);
  modport slave  (input pkt_data, input pkt_valid, output pkt_ready);
endinterface

// File: rtl/spi_packet_rx.sv
// rtl/spi_packet_rx.sv - oversampled SPI slave packet receiver with header/length/checksum checks
module spi_packet_rx #(
  parameter int         PACKET_BYTES = 16,
  parameter logic [7:0] HEADER_BYTE  = 8'hAA,
  parameter bit         CPOL         = 1'b0,
  parameter bit         CPHA         = 1'b0,
  parameter bit         CHECKSUM_EN  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cs_n,
  input  logic                   sck,
  input  logic                   sdi,
  spi_packet_rx_if.master        pkt,
  output logic                   initialized,
  output logic                   error,
  output logic [2:0]             err_code,
  output logic [15:0]            pkt_cnt,
  output logic [7:0]             err_cnt
);
  localparam int IDX_W = $clog2(PACKET_BYTES + 1);
  localparam int BUF_W = $clog2(PACKET_BYTES);
  localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(PACKET_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

  state_t state, state_next;

  logic cs_meta, cs_sync, cs_d1, cs_d2;
  logic sck_meta, sck_sync, sck_d1;
  logic sdi_meta, sdi_sync;
  logic [1:0] fill;
  logic armed;

  logic cs_fall, cs_rise, sck_rise, sck_fall, sample_edge;
  logic start, sample, check;

  logic [7:0]       shreg;
  logic [2:0]       bit_idx;
  logic [IDX_W-1:0] byte_idx;
  logic             overflow;
  logic [7:0]       xor_acc;
  logic [7:0]       rx_buf [PACKET_BYTES];
  logic [7:0]       byte_new;
  logic [BUF_W-1:0] wr_ptr;
  logic [8*PACKET_BYTES-1:0] buf_flat;

  logic len_err, hdr_err, csum_err, good, slot_free;

  // Bring the SPI pins into the clk domain; cs_n gets two extra stages so a
  // sample edge coincident with the cs_n rise still lands before CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta  <= 1'b1;
      cs_sync  <= 1'b1;
      cs_d1    <= 1'b1;
      cs_d2    <= 1'b1;
      sck_meta <= CPOL;
      sck_sync <= CPOL;
      sck_d1   <= CPOL;
      sdi_meta <= 1'b0;
      sdi_sync <= 1'b0;
    end else begin
      cs_meta  <= cs_n;
      cs_sync  <= cs_meta;
      cs_d1    <= cs_sync;
      cs_d2    <= cs_d1;
      sck_meta <= sck;
      sck_sync <= sck_meta;
      sck_d1   <= sck_sync;
      sdi_meta <= sdi;
      sdi_sync <= sdi_meta;
    end
  end

  // Arm only after a genuine cs_n high has travelled the pipeline, so a
  // transaction already running when reset releases is never joined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill  <= 2'd0;
      armed <= 1'b0;
    end else begin
      if (fill != 2'd3) fill <= fill + 2'd1;
      if (fill == 2'd3 && cs_d1) armed <= 1'b1;
    end
  end

  assign cs_fall     = ~cs_d1 & cs_d2 & armed;
  assign cs_rise     = cs_d1 & ~cs_d2;
  assign sck_rise    = sck_sync & ~sck_d1;
  assign sck_fall    = ~sck_sync & sck_d1;
  assign sample_edge = (CPOL == CPHA) ? sck_rise : sck_fall;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM next state and per-state strobes.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    sample     = 1'b0;
    check      = 1'b0;
    case (state)
      S_IDLE: begin
        if (cs_fall) begin
          state_next = S_RECV;
          start      = 1'b1;
        end
      end
      S_RECV: begin
        sample = sample_edge;
        if (cs_rise) state_next = S_CHECK;
      end
      S_CHECK: begin
        check      = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign byte_new = {shreg[6:0], sdi_sync};
  assign wr_ptr   = byte_idx[BUF_W-1:0];

  // Shift in bits MSB first, land whole bytes, fold the payload into the checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= 8'd0;
      bit_idx  <= 3'd0;
      byte_idx <= '0;
      overflow <= 1'b0;
      xor_acc  <= 8'd0;
      for (int i = 0; i < PACKET_BYTES; i++) rx_buf[i] <= 8'd0;
    end else if (start) begin
      shreg    <= 8'd0;
      bit_idx  <= 3'd0;
      byte_idx <= '0;
      overflow <= 1'b0;
      xor_acc  <= 8'd0;
    end else if (sample) begin
      shreg   <= byte_new;
      bit_idx <= bit_idx + 3'd1;
      if (bit_idx == 3'd7) begin
        if (byte_idx == FULL_IDX) begin
          overflow <= 1'b1;
        end else begin
          rx_buf[wr_ptr] <= byte_new;
          byte_idx       <= byte_idx + IDX_W'(1);
          if (byte_idx < LAST_IDX) xor_acc <= xor_acc ^ byte_new;
        end
      end
    end
  end

  // Flatten the receive buffer with byte 0 in the low bits.
  always_comb begin
    buf_flat = '0;
    for (int i = 0; i < PACKET_BYTES; i++) buf_flat[8*i +: 8] = rx_buf[i];
  end

  assign len_err   = overflow | (byte_idx != FULL_IDX) | (bit_idx != 3'd0);
  assign hdr_err   = rx_buf[0] != HEADER_BYTE;
  assign csum_err  = CHECKSUM_EN & (xor_acc != rx_buf[PACKET_BYTES-1]);
  assign good      = ~(len_err | hdr_err | csum_err);
  assign slot_free = ~pkt.pkt_valid | pkt.pkt_ready;

  // Holding register, handshake and status: a good packet loads only into a
  // free slot, otherwise it is an overrun and only err_cnt moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt.pkt_data  <= '0;
      pkt.pkt_valid <= 1'b0;
      initialized   <= 1'b0;
      error         <= 1'b0;
      err_code      <= 3'd0;
      pkt_cnt       <= 16'd0;
      err_cnt       <= 8'd0;
    end else begin
      if (pkt.pkt_valid && pkt.pkt_ready) pkt.pkt_valid <= 1'b0;
      if (check) begin
        if (good && slot_free) begin
          pkt.pkt_data  <= buf_flat;
          pkt.pkt_valid <= 1'b1;
          pkt_cnt       <= pkt_cnt + 16'd1;
          initialized   <= 1'b1;
          error         <= 1'b0;
          err_code      <= 3'd0;
        end else begin
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          if (!good) begin
            error    <= 1'b1;
            err_code <= {len_err, hdr_err, csum_err};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_packet_rx.sv
// tb/tb_spi_packet_rx.sv - self-checking bench for spi_packet_rx in SPI modes 0, 3 and 1
module tb_spi_packet_rx;
  localparam int P  = 16;
  localparam int DW = 8 * P;
  typedef logic [DW-1:0] word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs_n = 1'b1;
  logic sck_a = 1'b0;
  logic sck_b;
  logic sdi_p0 = 1'b0;
  logic sdi_p1 = 1'b0;
  logic pkt_ready = 1'b0;

  assign sck_b = ~sck_a;

  always #5 clk = ~clk;

  spi_packet_rx_if #(.PACKET_BYTES(P)) if0 ();
  spi_packet_rx_if #(.PACKET_BYTES(P)) if3 ();
  spi_packet_rx_if #(.PACKET_BYTES(P)) if1 ();

  assign if0.pkt_ready = pkt_ready;
  assign if3.pkt_ready = pkt_ready;
  assign if1.pkt_ready = pkt_ready;

  logic [2:0]  valid_o, init_o, err_o;
  logic [2:0]  code_o [3];
  logic [15:0] cnt_o  [3];
  logic [7:0]  ecnt_o [3];
  word_t       data_o [3];

  assign valid_o[0] = if0.pkt_valid;
  assign valid_o[1] = if3.pkt_valid;
  assign valid_o[2] = if1.pkt_valid;
  assign data_o[0]  = if0.pkt_data;
  assign data_o[1]  = if3.pkt_data;
  assign data_o[2]  = if1.pkt_data;

  spi_packet_rx #(.PACKET_BYTES(P), .HEADER_BYTE(8'hAA), .CPOL(1'b0), .CPHA(1'b0), .CHECKSUM_EN(1'b1)) u_mode0 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck_a), .sdi(sdi_p0), .pkt(if0),
    .initialized(init_o[0]), .error(err_o[0]), .err_code(code_o[0]), .pkt_cnt(cnt_o[0]), .err_cnt(ecnt_o[0]));

  spi_packet_rx #(.PACKET_BYTES(P), .HEADER_BYTE(8'hAA), .CPOL(1'b1), .CPHA(1'b1), .CHECKSUM_EN(1'b1)) u_mode3 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck_b), .sdi(sdi_p1), .pkt(if3),
    .initialized(init_o[1]), .error(err_o[1]), .err_code(code_o[1]), .pkt_cnt(cnt_o[1]), .err_cnt(ecnt_o[1]));

  spi_packet_rx #(.PACKET_BYTES(P), .HEADER_BYTE(8'hAA), .CPOL(1'b0), .CPHA(1'b1), .CHECKSUM_EN(1'b1)) u_mode1 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck_a), .sdi(sdi_p1), .pkt(if1),
    .initialized(init_o[2]), .error(err_o[2]), .err_code(code_o[2]), .pkt_cnt(cnt_o[2]), .err_cnt(ecnt_o[2]));

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx [20];
  logic [7:0]  m_buf [P];
  word_t       m_data;
  logic        m_valid, m_init, m_error;
  logic [2:0]  m_code;
  logic [15:0] m_cnt;
  logic [7:0]  m_ecnt;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    string mname [3];
    mname = '{"mode0", "mode3", "mode1"};
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s %s pkt_valid", step, mname[k]), word_t'(valid_o[k]), word_t'(m_valid));
      check($sformatf("%s %s pkt_data", step, mname[k]), data_o[k], m_data);
      check($sformatf("%s %s initialized", step, mname[k]), word_t'(init_o[k]), word_t'(m_init));
      check($sformatf("%s %s error", step, mname[k]), word_t'(err_o[k]), word_t'(m_error));
      check($sformatf("%s %s err_code", step, mname[k]), word_t'(code_o[k]), word_t'(m_code));
      check($sformatf("%s %s pkt_cnt", step, mname[k]), word_t'(cnt_o[k]), word_t'(m_cnt));
      check($sformatf("%s %s err_cnt", step, mname[k]), word_t'(ecnt_o[k]), word_t'(m_ecnt));
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_valid = 1'b0; m_init = 1'b0; m_error = 1'b0;
    m_code = 3'd0; m_cnt = 16'd0; m_ecnt = 8'd0;
    for (int i = 0; i < P; i++) m_buf[i] = 8'd0;
  endtask

  // Reference: whole bytes land up to P, anything but exactly 8*P bits is a
  // length error, header/checksum are judged on whatever the buffer holds.
  task automatic model_txn(input int nbits, input logic rdy);
    int landed;
    logic [7:0] x;
    logic len, hdr, cs, good, free;
    landed = (nbits / 8 > P) ? P : nbits / 8;
    x = 8'd0;
    for (int i = 0; i < landed; i++) begin
      m_buf[i] = tx[i];
      if (i < P - 1) x = x ^ tx[i];
    end
    len  = (nbits != 8 * P);
    hdr  = (m_buf[0] != 8'hAA);
    cs   = (x != m_buf[P-1]);
    good = !(len || hdr || cs);
    free = !m_valid || rdy;
    if (good && free) begin
      for (int i = 0; i < P; i++) m_data[8*i +: 8] = m_buf[i];
      m_valid = 1'b1; m_cnt = m_cnt + 16'd1; m_init = 1'b1; m_error = 1'b0; m_code = 3'd0;
    end else begin
      if (rdy) m_valid = 1'b0;
      if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
      if (!good) begin
        m_error = 1'b1;
        m_code  = {len, hdr, cs};
      end
    end
  endtask

  task automatic seal();
    logic [7:0] x;
    x = 8'd0;
    for (int i = 0; i < P - 1; i++) x = x ^ tx[i];
    tx[P-1] = x;
  endtask

  task automatic fill_random(input logic [7:0] hdr);
    tx[0] = hdr;
    for (int i = 1; i < 20; i++) tx[i] = 8'($urandom);
    seal();
  endtask

  task automatic send_bits(input int from, input int to);
    for (int b = from; b < to; b++) begin
      logic [7:0] byte_v;
      logic v;
      byte_v = tx[b / 8];
      v = byte_v[7 - (b % 8)];
      sdi_p0 = v;
      repeat (5) @(negedge clk);
      sck_a  = 1'b1;
      sdi_p1 = v;
      repeat (5) @(negedge clk);
      sck_a  = 1'b0;
    end
  endtask

  // One full transaction; outputs must hold through t0+3 and update at t0+4.
  task automatic run(input int nbits, input logic rdy, input string step);
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(0, nbits);
    repeat (6) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_all({step, " pre"});
    pkt_ready = rdy;
    @(posedge clk);
    @(negedge clk);
    pkt_ready = 1'b0;
    model_txn(nbits, rdy);
    check_all(step);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_ready(input string step);
    @(negedge clk);
    pkt_ready = 1'b1;
    @(negedge clk);
    pkt_ready = 1'b0;
    m_valid = 1'b0;
    check_all(step);
  endtask

  initial begin
    model_reset();
    repeat (4) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    tx[0] = 8'hAA;
    for (int i = 1; i < P - 1; i++) tx[i] = 8'(i);
    seal();
    run(128, 1'b0, "good0");
    for (int k = 0; k < 3; k++) begin
      check("good0 byte0", word_t'(data_o[k][7:0]), word_t'(8'hAA));
      check("good0 csum byte", word_t'(data_o[k][DW-1 -: 8]), word_t'(tx[P-1]));
    end

    run(120, 1'b0, "len15");
    check("len15 code", word_t'(code_o[0]), word_t'(3'b100));
    run(136, 1'b0, "len17");
    check("len17 code", word_t'(code_o[0]), word_t'(3'b100));
    run(131, 1'b0, "len16p3");
    check("len16p3 code", word_t'(code_o[0]), word_t'(3'b100));
    tx[0] = 8'h55;
    seal();
    run(128, 1'b0, "hdr");
    check("hdr code", word_t'(code_o[0]), word_t'(3'b010));
    tx[0] = 8'hAA;
    seal();
    tx[P-1] = tx[P-1] ^ 8'h10;
    run(128, 1'b0, "csum");
    check("csum code", word_t'(code_o[0]), word_t'(3'b001));
    check("fault err_cnt", word_t'(ecnt_o[0]), word_t'(8'd5));

    pulse_ready("drain0");
    fill_random(8'hAA);
    run(128, 1'b0, "ovr first");
    fill_random(8'hAA);
    run(128, 1'b0, "ovr second");
    pulse_ready("ovr drain");

    fill_random(8'hAA);
    run(128, 1'b0, "acc first");
    fill_random(8'hAA);
    run(128, 1'b1, "acc load");
    check("acc load valid", word_t'(valid_o[1]), word_t'(1'b1));
    pulse_ready("acc drain");

    for (int n = 0; n < 6; n++) begin
      int kind, nbits;
      kind  = $urandom_range(0, 4);
      nbits = 128;
      fill_random(8'hAA);
      if (kind == 1) begin tx[0] = 8'($urandom_range(0, 255)); seal(); end
      if (kind == 2) tx[P-1] = tx[P-1] ^ 8'($urandom_range(1, 255));
      if (kind == 3) nbits = 128 + $urandom_range(1, 12) - 6;
      run(nbits, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    run(0, 1'b0, "zero");
    check("zero len bit", word_t'(code_o[2][2]), word_t'(1'b1));

    fill_random(8'hAA);
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(0, 40);
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    check_all("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_bits(40, 128);
    repeat (6) @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check_all("midrst tail");
    fill_random(8'hAA);
    run(128, 1'b0, "after rst");
    check("after rst cnt", word_t'(cnt_o[0]), word_t'(16'd1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    checks++;
    errors++;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
